micro_seq: RTL

Micro-procedure sequencer: bus master for the SoC-demo micro-procedure ROM/register-file peripheral. On a start request it fetches 32-bit micro-words from the procedure region, reads operands from the GPR/temp/constant/rz window, executes a small ALU or branch operation, and writes results back over the shared `mem_we`/`mem_addr`/`mem_data` bus. It sits directly upstream of that peripheral and is the only master on this bus while `busy` is high.

---
 rtl/micro_pkg.sv | 69 ++++++
 rtl/micro_alu.sv | 30 +++
 rtl/micro_seq.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/micro_pkg.sv
// micro_pkg: shared definitions for the micro-procedure sequencer.
//   - bus region bases, opcode values, FSM state encoding
//   - micro-word field positions and a decode helper
//   - operand-window region indices (const, mask-const, rz)
package micro_pkg;

    localparam logic [31:0] PRC_BASE = 32'hffffe000;
    localparam logic [31:0] REG_BASE = 32'hffffc000;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_MOV  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_SLL  = 4'h7;
    localparam logic [3:0] OP_SRL  = 4'h8;
    localparam logic [3:0] OP_BEQZ = 4'h9;
    localparam logic [3:0] OP_BNEZ = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_RET  = 4'hF;

    localparam int OP_LO  = 28;
    localparam int DST_LO = 20;
    localparam int A_LO   = 12;
    localparam int B_LO   = 4;
    localparam int TGT_LO = 0;

    localparam logic [7:0] IDX_CONST = 8'd64;
    localparam logic [7:0] IDX_MASK  = 8'd96;
    localparam logic [7:0] IDX_RZ    = 8'd128;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_RDA, S_RDB, S_WR, S_FIN
    } state_t;

    // tgt overlaps b; only branches interpret it
    typedef struct packed {
        logic [3:0] op;
        logic [7:0] dst;
        logic [7:0] a;
        logic [7:0] b;
        logic [9:0] tgt;
    } uword_t;

    function automatic uword_t decode(input logic [31:0] w);
        uword_t u;
        u.op  = w[OP_LO  +: 4];
        u.dst = w[DST_LO +: 8];
        u.a   = w[A_LO   +: 8];
        u.b   = w[B_LO   +: 8];
        u.tgt = w[TGT_LO +: 10];
        return u;
    endfunction

    function automatic logic [31:0] prc_addr(input logic [9:0] pc);
        return PRC_BASE + {20'b0, pc, 2'b00};
    endfunction

    function automatic logic [31:0] reg_addr(input logic [7:0] idx);
        return REG_BASE + {22'b0, idx, 2'b00};
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        return (op == 4'hC) || (op == 4'hD) || (op == 4'hE);
    endfunction

endpackage

// File: rtl/micro_alu.sv
// micro_alu: combinational datapath for MOV and the ALU opcodes.
//   op  in  4   opcode (1..8 meaningful, others give 0)
//   a   in  32  first operand
//   b   in  32  second operand (shift amount uses b[4:0])
//   y   out 32  result, 32-bit wrap-around
module micro_alu
    import micro_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_MOV:  y = a;
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_SLL:  y = a << b[4:0];
            OP_SRL:  y = a >> b[4:0];
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/micro_seq.sv
// micro_seq: micro-procedure sequencer, sole bus master while busy.
//   clk, rst       clock, synchronous active-high reset
//   start, entry   one-cycle request with first micro-word index
//   busy, done     running flag, one-cycle completion pulse
//   err            illegal opcode / watchdog, valid with done, held to next start
//   mem_we         write strobe (masked by rst so an in-flight write is dropped)
//   mem_addr       registered byte address, updated on state entry
//   mem_data       driven only while mem_we; otherwise read data from peripheral
module micro_seq
    import micro_pkg::*;
#(
    parameter int MAX_STEPS = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [9:0]  entry,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    inout  wire  [31:0] mem_data
);

    localparam int SW = $clog2(MAX_STEPS + 1);

    state_t        state;
    logic [9:0]    pc;
    logic [SW-1:0] steps;
    logic [3:0]    ir_op;
    logic [7:0]    ir_dst;
    logic [7:0]    ir_b;
    logic [9:0]    ir_tgt;
    logic [31:0]   a_q;
    logic [31:0]   wdata;
    logic          we_q;

    // Read data arrives combinationally, so decode straight off the bus.
    uword_t        fw;
    logic [SW-1:0] steps_inc;
    logic [9:0]    pc_inc;
    logic [9:0]    br_pc;
    logic [31:0]   alu_a;
    logic [31:0]   alu_y;

    assign fw        = decode(mem_data);
    assign steps_inc = steps + 1'b1;
    assign pc_inc    = pc + 10'd1;
    assign br_pc     = ((mem_data == 32'd0) == (ir_op == OP_BEQZ)) ? ir_tgt : pc_inc;
    // MOV resolves in RDA while A is still on the bus
    assign alu_a     = (state == S_RDA) ? mem_data : a_q;

    micro_alu u_alu (
        .op (ir_op),
        .a  (alu_a),
        .b  (mem_data),
        .y  (alu_y)
    );

    assign mem_we   = we_q & ~rst;
    assign mem_data = mem_we ? wdata : 'z;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            pc       <= '0;
            steps    <= '0;
            ir_op    <= '0;
            ir_dst   <= '0;
            ir_b     <= '0;
            ir_tgt   <= '0;
            a_q      <= '0;
            wdata    <= '0;
            we_q     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            mem_addr <= '0;
        end else begin
            done <= 1'b0;
            we_q <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    pc       <= entry;
                    steps    <= '0;
                    err      <= 1'b0;
                    busy     <= 1'b1;
                    mem_addr <= prc_addr(entry);
                    state    <= S_FETCH;
                end
                S_FETCH: begin
                    ir_op  <= fw.op;
                    ir_dst <= fw.dst;
                    ir_b   <= fw.b;
                    ir_tgt <= fw.tgt;
                    steps  <= steps_inc;
                    if (fw.op == OP_RET) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_FIN;
                    end else if (is_illegal(fw.op) || steps_inc == SW'(MAX_STEPS)) begin
                        // abort without touching the bus again
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_FIN;
                    end else begin
                        case (fw.op)
                            OP_NOP: begin
                                pc       <= pc_inc;
                                mem_addr <= prc_addr(pc_inc);
                            end
                            OP_JMP: begin
                                pc       <= fw.tgt;
                                mem_addr <= prc_addr(fw.tgt);
                            end
                            default: begin
                                mem_addr <= reg_addr(fw.a);
                                state    <= S_RDA;
                            end
                        endcase
                    end
                end
                S_RDA: begin
                    a_q <= mem_data;
                    case (ir_op)
                        OP_MOV: begin
                            wdata    <= alu_y;
                            we_q     <= 1'b1;
                            mem_addr <= reg_addr(ir_dst);
                            state    <= S_WR;
                        end
                        OP_BEQZ, OP_BNEZ: begin
                            pc       <= br_pc;
                            mem_addr <= prc_addr(br_pc);
                            state    <= S_FETCH;
                        end
                        default: begin
                            mem_addr <= reg_addr(ir_b);
                            state    <= S_RDB;
                        end
                    endcase
                end
                S_RDB: begin
                    wdata    <= alu_y;
                    we_q     <= 1'b1;
                    mem_addr <= reg_addr(ir_dst);
                    state    <= S_WR;
                end
                S_WR: begin
                    pc       <= pc_inc;
                    mem_addr <= prc_addr(pc_inc);
                    state    <= S_FETCH;
                end
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
